mem_stage_sp: RTL and testbench
===============================

# mem_stage_sp

Parametrised memory-stage block for the five-stage pipeline. It selects the address and write data from the Rsrc/Rdst operand bus and owns the data memory array. It also keeps a stack pointer for single-word and double-word (wide) push/pop, with a two-beat sequencer that stalls the pipeline on wide accesses. It sits between the execute stage and the write-back stage, and its read result is registered so it arrives as the MEM/WB value.

## Interface
- W, 16, data word width.
- AW, 11, memory address width; depth = 2^AW words.
- SP_RESET, 2^AW-1, stack pointer value after reset.

Ports:
- clk  in  1  clock; rising edge active.
- rst  in  1  asynchronous, active-low reset.
- data_in  in  2W  operand bus; [W-1:0] is Rdst, [2W-1:W] is Rsrc.
- memRead  in  1  load request.
- memWrite  in  1  store request.
- memAddress  in  1  1: address = Rdst; 0: address = Rsrc (low AW bits used).
- memData  in  1  1: write data = Rdst; 0: write data = Rsrc.
- push  in  1  stack push request.
- pop  in  1  stack pop request.
- wide  in  1  with push/pop: two-word access of the full 2W bus.
- RD  out  2W  registered read data.
- rd_valid  out  1  RD updated this cycle (one-cycle pulse).
- stall  out  1  block busy with beat 2; upstream must hold.
- sp  out  AW  current stack pointer.
- fault  out  1  one-cycle pulse; stack op rejected.

## Operation
- Command priority when several requests are high: push > pop > memWrite > memRead. Only the winner executes.
- Address is truncated to AW bits, so it wraps modulo 2^AW.
- Memory has a synchronous write and a registered read. Memory contents are not reset.
- Store: mem[addr] <= WD.
- Load: RD <= {W'b0, mem[addr]}, rd_valid=1.
- Narrow push: mem[sp] <= WD, sp <= sp-1.
- Narrow pop: RD <= {0, mem[sp+1]}, sp <= sp+1.
- Wide push (2 beats):
  - beat 1: mem[sp] <= Rsrc;
  - beat 2: mem[sp-1] <= Rdst, sp <= sp-2.
- Wide pop (2 beats):
  - beat 1 reads mem[sp+1] into RD[W-1:0];
  - beat 2 reads mem[sp+2] into RD[2W-1:W], sp <= sp+2;
  - rd_valid pulses after beat 2 only.
- Operands for beat 2 are captured at beat 1, so later changes to data_in have no effect.
- Overflow and underflow checks:
  - narrow push with sp==0, or wide push with sp<2, is suppressed;
  - narrow pop with sp==2^AW-1, or wide pop with sp>2^AW-3, is suppressed;
  - a suppressed op pulses fault, and sp and the memory are unchanged.
- State machine:
  - IDLE: accepts commands. An accepted wide push/pop without fault goes to BEAT2; everything else stays in IDLE.
  - BEAT2: stall=1 and all inputs are ignored. Completes the second access, then returns to IDLE.
- Reset values: RD=0, rd_valid=0, stall=0, fault=0, sp=SP_RESET, state IDLE.

## Timing
- Commands are sampled at rising edge N. For narrow ops, RD/rd_valid/sp/fault update at edge N, so they are visible during cycle N+1.
- A store at edge N is readable by a load sampled at edge N+1 (no bypass is needed).
- Wide ops: stall is high from edge N to edge N+1 and is driven combinationally from state. Final sp and RD update at edge N+1.
- Back-to-back narrow ops run one per cycle with no bubbles. A new command is accepted at the edge on which BEAT2 completes only if it was sampled in IDLE; the command held during BEAT2 is accepted at the following edge.
- Reset asserted mid-BEAT2: aborts immediately. A partially completed wide push leaves the beat-1 word in memory; sp returns to SP_RESET and stall drops asynchronously.
- rd_valid is low in every cycle without a completed read; RD holds its last value.

## Test plan
- Reset, then store data_in=0x1234_0055 with memAddress=1, memData=0 (mem[0x055] <= 0x1234); load the same address next cycle -> RD=0x0000_1234, rd_valid one cycle later.
- Narrow push 0xBEEF from sp=0x7FF -> sp=0x7FE; pop -> RD=0x0000BEEF, sp=0x7FF.
- Wide push of 0xAAAA_5555 -> stall high exactly one cycle, sp=0x7FD; wide pop -> RD=0xAAAA5555, rd_valid once, sp=0x7FF.
- Pop at sp=0x7FF -> fault pulse, sp unchanged, rd_valid=0.
- push, memWrite and memRead asserted together -> only the push executes.
- Assert rst during BEAT2 of a wide push -> stall=0, sp=0x7FF, beat-1 word present in memory.

Source files
------------

// File: rtl/mem_stage_sp.sv
// Memory stage: operand-bus address/data select, data memory and a stack pointer
// with a two-beat sequencer for wide (2W) push/pop that stalls the pipeline.
module mem_stage_sp #(
  parameter int unsigned     W        = 16,
  parameter int unsigned     AW       = 11,
  parameter logic [AW-1:0]   SP_RESET = {AW{1'b1}}
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2*W-1:0]  data_in,
  input  logic            memRead,
  input  logic            memWrite,
  input  logic            memAddress,
  input  logic            memData,
  input  logic            push,
  input  logic            pop,
  input  logic            wide,
  output logic [2*W-1:0]  RD,
  output logic            rd_valid,
  output logic            stall,
  output logic [AW-1:0]   sp,
  output logic            fault
);

  localparam int unsigned   DEPTH  = 1 << AW;
  localparam logic [AW-1:0] SP_MAX = {AW{1'b1}};

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BEAT2 = 1'b1
  } state_e;

  logic [W-1:0]   mem_q [DEPTH];

  state_e         state_q, state_d;
  logic [AW-1:0]  sp_q, sp_d;
  logic [2*W-1:0] rd_q, rd_d;
  logic           rd_valid_q, rd_valid_d;
  logic           fault_q, fault_d;
  logic [W-1:0]   hold_q, hold_d;
  logic           pop_op_q, pop_op_d;

  logic           we_s;
  logic [AW-1:0]  waddr_s;
  logic [W-1:0]   wdata_s;

  logic [W-1:0]   rdst_s, rsrc_s, wd_s;
  logic [AW-1:0]  addr_s;
  logic [AW-1:0]  sp_p1_s, sp_p2_s, sp_m1_s, sp_m2_s;

  assign rdst_s  = data_in[W-1:0];
  assign rsrc_s  = data_in[2*W-1:W];
  assign addr_s  = memAddress ? rdst_s[AW-1:0] : rsrc_s[AW-1:0];
  assign wd_s    = memData ? rdst_s : rsrc_s;
  assign sp_p1_s = sp_q + AW'(1);
  assign sp_p2_s = sp_q + AW'(2);
  assign sp_m1_s = sp_q - AW'(1);
  assign sp_m2_s = sp_q - AW'(2);

  // Command arbitration, stack bounds checks and beat sequencing
  always_comb begin
    state_d    = state_q;
    sp_d       = sp_q;
    rd_d       = rd_q;
    rd_valid_d = 1'b0;
    fault_d    = 1'b0;
    hold_d     = hold_q;
    pop_op_d   = pop_op_q;
    we_s       = 1'b0;
    waddr_s    = sp_q;
    wdata_s    = wd_s;

    case (state_q)
      S_IDLE: begin
        if (push) begin
          if (wide) begin
            if (sp_q < AW'(2)) begin
              fault_d = 1'b1;
            end else begin
              // Rdst is parked for beat 2 so later bus changes cannot leak in
              we_s     = 1'b1;
              waddr_s  = sp_q;
              wdata_s  = rsrc_s;
              hold_d   = rdst_s;
              pop_op_d = 1'b0;
              state_d  = S_BEAT2;
            end
          end else begin
            if (sp_q == {AW{1'b0}}) begin
              fault_d = 1'b1;
            end else begin
              we_s    = 1'b1;
              waddr_s = sp_q;
              wdata_s = wd_s;
              sp_d    = sp_m1_s;
            end
          end
        end else if (pop) begin
          if (wide) begin
            if (sp_q > SP_MAX - AW'(2)) begin
              fault_d = 1'b1;
            end else begin
              hold_d   = mem_q[sp_p1_s];
              pop_op_d = 1'b1;
              state_d  = S_BEAT2;
            end
          end else begin
            if (sp_q == SP_MAX) begin
              fault_d = 1'b1;
            end else begin
              rd_d       = {{W{1'b0}}, mem_q[sp_p1_s]};
              rd_valid_d = 1'b1;
              sp_d       = sp_p1_s;
            end
          end
        end else if (memWrite) begin
          we_s    = 1'b1;
          waddr_s = addr_s;
          wdata_s = wd_s;
        end else if (memRead) begin
          rd_d       = {{W{1'b0}}, mem_q[addr_s]};
          rd_valid_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_BEAT2: begin
        state_d = S_IDLE;
        if (pop_op_q) begin
          rd_d       = {mem_q[sp_p2_s], hold_q};
          rd_valid_d = 1'b1;
          sp_d       = sp_p2_s;
        end else begin
          we_s    = 1'b1;
          waddr_s = sp_m1_s;
          wdata_s = hold_q;
          sp_d    = sp_m2_s;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      sp_q       <= SP_RESET;
      rd_q       <= {(2*W){1'b0}};
      rd_valid_q <= 1'b0;
      fault_q    <= 1'b0;
      hold_q     <= {W{1'b0}};
      pop_op_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sp_q       <= sp_d;
      rd_q       <= rd_d;
      rd_valid_q <= rd_valid_d;
      fault_q    <= fault_d;
      hold_q     <= hold_d;
      pop_op_q   <= pop_op_d;
    end
  end

  // Data array: synchronous write, contents deliberately not reset
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_q[waddr_s] <= wdata_s;
    end
  end

  assign RD       = rd_q;
  assign rd_valid = rd_valid_q;
  assign fault    = fault_q;
  assign sp       = sp_q;
  assign stall    = (state_q == S_BEAT2);

endmodule

// File: tb/tb_mem_stage_sp.sv
// Self-checking bench for mem_stage_sp: directed scenarios plus randomized traffic
// against a transaction-level model of the memory, stack pointer and read port.
module tb_mem_stage_sp;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] data_in = 32'h0;
  logic        memRead = 1'b0, memWrite = 1'b0, memAddress = 1'b0, memData = 1'b0;
  logic        push = 1'b0, pop = 1'b0, wide = 1'b0;
  logic [31:0] RD;
  logic        rd_valid, stall, fault;
  logic [10:0] sp;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [15:0] m_mem [2048];
  int          m_sp;
  logic [31:0] m_rd;
  bit          m_busy;
  bit          exp_valid, exp_fault;
  bit          p_is_pop;
  logic [31:0] p_rd;
  int          p_sp;
  int          p_waddr;
  logic [15:0] p_wdata;

  mem_stage_sp dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .memRead    (memRead),
    .memWrite   (memWrite),
    .memAddress (memAddress),
    .memData    (memData),
    .push       (push),
    .pop        (pop),
    .wide       (wide),
    .RD         (RD),
    .rd_valid   (rd_valid),
    .stall      (stall),
    .sp         (sp),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_sp      = 2047;
    m_rd      = 32'h0;
    m_busy    = 1'b0;
    exp_valid = 1'b0;
    exp_fault = 1'b0;
  endfunction

  // A wide op is resolved as a whole when accepted; its second half lands one edge later.
  function automatic void model_edge(input bit i_push, input bit i_pop, input bit i_wide,
                                     input bit i_wr, input bit i_rd, input bit i_ma,
                                     input bit i_md, input logic [31:0] din);
    logic [15:0] rdst, rsrc, wd;
    int addr;
    exp_valid = 1'b0;
    exp_fault = 1'b0;
    rdst = din[15:0];
    rsrc = din[31:16];
    wd   = i_md ? rdst : rsrc;
    addr = i_ma ? int'(rdst[10:0]) : int'(rsrc[10:0]);
    if (m_busy) begin
      m_busy = 1'b0;
      m_sp   = p_sp;
      if (p_is_pop) begin
        m_rd      = p_rd;
        exp_valid = 1'b1;
      end else begin
        m_mem[p_waddr] = p_wdata;
      end
    end else if (i_push) begin
      if (!i_wide) begin
        if (m_sp == 0) exp_fault = 1'b1;
        else begin
          m_mem[m_sp] = wd;
          m_sp = m_sp - 1;
        end
      end else begin
        if (m_sp < 2) exp_fault = 1'b1;
        else begin
          m_mem[m_sp] = rsrc;
          m_busy   = 1'b1;
          p_is_pop = 1'b0;
          p_waddr  = m_sp - 1;
          p_wdata  = rdst;
          p_sp     = m_sp - 2;
        end
      end
    end else if (i_pop) begin
      if (!i_wide) begin
        if (m_sp == 2047) exp_fault = 1'b1;
        else begin
          m_rd      = {16'h0, m_mem[m_sp + 1]};
          exp_valid = 1'b1;
          m_sp      = m_sp + 1;
        end
      end else begin
        if (m_sp > 2045) exp_fault = 1'b1;
        else begin
          m_busy   = 1'b1;
          p_is_pop = 1'b1;
          p_rd     = {m_mem[m_sp + 2], m_mem[m_sp + 1]};
          p_sp     = m_sp + 2;
        end
      end
    end else if (i_wr) begin
      m_mem[addr] = wd;
    end else if (i_rd) begin
      m_rd      = {16'h0, m_mem[addr]};
      exp_valid = 1'b1;
    end
  endfunction

  task automatic compare_all();
    check("RD", RD, m_rd);
    check("rd_valid", {31'h0, rd_valid}, {31'h0, exp_valid});
    check("fault", {31'h0, fault}, {31'h0, exp_fault});
    check("stall", {31'h0, stall}, {31'h0, m_busy});
    check("sp", {21'h0, sp}, m_sp[31:0]);
  endtask

  // Drive one command from a negedge, let the model follow the edge, compare at the next negedge.
  task automatic cyc(input bit i_push, input bit i_pop, input bit i_wide, input bit i_wr,
                     input bit i_rd, input bit i_ma, input bit i_md, input logic [31:0] din);
    push = i_push; pop = i_pop; wide = i_wide; memWrite = i_wr; memRead = i_rd;
    memAddress = i_ma; memData = i_md; data_in = din;
    @(posedge clk);
    model_edge(i_push, i_pop, i_wide, i_wr, i_rd, i_ma, i_md, din);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("reset_RD", RD, 32'h0);
    check("reset_valid", {31'h0, rd_valid}, 32'h0);
    check("reset_stall", {31'h0, stall}, 32'h0);
    check("reset_fault", {31'h0, fault}, 32'h0);
    check("reset_sp", {21'h0, sp}, 32'h7FF);

    // store via Rdst address, Rsrc data, then load it back
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1234_0055);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h1234_0055);
    check("load_RD", RD, 32'h0000_1234);
    check("load_valid", {31'h0, rd_valid}, 32'h1);
    idle();

    // narrow push / pop
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_BEEF);
    check("npush_sp", {21'h0, sp}, 32'h7FE);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("npop_RD", RD, 32'h0000_BEEF);
    check("npop_sp", {21'h0, sp}, 32'h7FF);

    // wide push / pop
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hAAAA_5555);
    check("wpush_stall1", {31'h0, stall}, 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF);
    check("wpush_stall2", {31'h0, stall}, 32'h0);
    check("wpush_sp", {21'h0, sp}, 32'h7FD);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("wpop_beat1_valid", {31'h0, rd_valid}, 32'h0);
    idle();
    check("wpop_RD", RD, 32'hAAAA_5555);
    check("wpop_valid", {31'h0, rd_valid}, 32'h1);
    check("wpop_sp", {21'h0, sp}, 32'h7FF);
    idle();

    // underflow
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("uflow_fault", {31'h0, fault}, 32'h1);
    check("uflow_sp", {21'h0, sp}, 32'h7FF);
    check("uflow_valid", {31'h0, rd_valid}, 32'h0);

    // push wins over memWrite and memRead
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0123_0055);
    check("prio_sp", {21'h0, sp}, 32'h7FE);
    check("prio_valid", {31'h0, rd_valid}, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0055);
    check("prio_mem", RD, 32'h0000_1234);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("prio_pop", RD, 32'h0000_0123);

    // reset during beat 2 of a wide push
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hCAFE_F00D);
    rst = 1'b0;
    #1;
    model_reset();
    check("rst_mid_stall", {31'h0, stall}, 32'h0);
    check("rst_mid_sp", {21'h0, sp}, 32'h7FF);
    @(negedge clk);
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_07FF);
    check("rst_mid_word", RD, 32'h0000_CAFE);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_07FE);

    // fill memory with a known pattern so random reads are well defined
    for (int a = 0; a < 2048; a++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, {16'(a * 7 + 3), 16'(a)});
    end

    // randomized traffic, commands kept on the bus even while stalled
    for (int i = 0; i < 4000; i++) begin
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 1) == 1, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
